round_controller: RTL and testbench

ROUND_CONTROLLER -- requirements
Module: round_controller

---
 rtl/round_controller_pkg.sv | 38 +++
 rtl/round_controller_hit_resolver.sv | 41 ++++
 rtl/round_controller.sv | 182 ++++++++++++++++++
 tb/tb_round_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_controller_pkg.sv
// Shared codes for the fighting-game round controller and the character FSMs.
package round_controller_pkg;

    typedef enum logic [3:0] {
        ST_IDLE             = 4'd0,
        ST_LEFT             = 4'd1,
        ST_RIGHT            = 4'd2,
        ST_ATTACK_1_START   = 4'd3,
        ST_ATTACK_1_ACTIVE  = 4'd4,
        ST_ATTACK_1_RECOVER = 4'd5,
        ST_ATTACK_2_START   = 4'd6,
        ST_ATTACK_2_ACTIVE  = 4'd7,
        ST_ATTACK_2_RECOVER = 4'd8,
        ST_DAMAGE           = 4'd9,
        ST_BLOCK            = 4'd10
    } char_state_t;

    typedef enum logic [2:0] {
        PH_WAIT_START = 3'd0,
        PH_COUNTDOWN  = 3'd1,
        PH_FIGHT      = 3'd2,
        PH_HITSTOP    = 3'd3,
        PH_ROUND_END  = 3'd4,
        PH_MATCH_OVER = 3'd5
    } phase_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_DRAW = 2'd3
    } winner_t;

    function automatic logic is_active(input logic [3:0] s);
        return (s == ST_ATTACK_1_ACTIVE) || (s == ST_ATTACK_2_ACTIVE);
    endfunction

endpackage

// File: rtl/round_controller_hit_resolver.sv
// One attacker/defender pair: reach test, once-per-attack latch, hit vs block.
module hit_resolver
    import round_controller_pkg::*;
#(
    parameter int         HIT_RANGE = 70,
    parameter logic [3:0] BACK_CODE = ST_LEFT
) (
    input  logic       clk_game,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear,
    input  logic [9:0] near_x,
    input  logic [9:0] far_x,
    input  logic [3:0] atk_state,
    input  logic [3:0] def_state,
    output logic       hit,
    output logic       block
);

    logic connected;
    logic active;
    logic reach;
    logic resolve;

    // Sprites crossed over (far left of near) never connect.
    assign reach   = (far_x >= near_x) && ((far_x - near_x) <= 10'(HIT_RANGE));
    assign active  = is_active(atk_state);
    assign resolve = enable && active && reach && !connected;
    assign block   = resolve && (def_state == BACK_CODE);
    assign hit     = resolve && (def_state != BACK_CODE);

    always_ff @(posedge clk_game or posedge reset) begin
        if (reset)
            connected <= 1'b0;
        else if (clear || !active)
            connected <= 1'b0;
        else if (resolve)
            connected <= 1'b1;
    end

endmodule

// File: rtl/round_controller.sv
// Match flow: countdown, fight, hitstop, round result and match over.
module round_controller
    import round_controller_pkg::*;
#(
    parameter int START_HEALTH     = 3,
    parameter int ROUNDS_TO_WIN    = 2,
    parameter int HIT_RANGE        = 70,
    parameter int COUNTDOWN_FRAMES = 120,
    parameter int HITSTOP_FRAMES   = 8,
    parameter int ROUND_END_FRAMES = 90,
    parameter int ROUND_SECONDS    = 60,
    parameter int FRAMES_PER_SEC   = 60
) (
    input  logic       clk_game,
    input  logic       reset,
    input  logic       start_button,
    input  logic [9:0] p1_x,
    input  logic [9:0] p2_x,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    output logic       p1_freeze,
    output logic       p2_freeze,
    output logic       p1_hit,
    output logic       p2_hit,
    output logic       p1_block,
    output logic       p2_block,
    output logic [2:0] p1_health,
    output logic [2:0] p2_health,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [2:0] phase,
    output logic [6:0] timer_sec,
    output logic [1:0] winner
);

    localparam logic [2:0]  START_H = 3'(START_HEALTH);
    localparam logic [6:0]  SECS    = 7'(ROUND_SECONDS);
    localparam logic [1:0]  RW      = 2'(ROUNDS_TO_WIN);
    localparam logic [15:0] CD_LAST = 16'(COUNTDOWN_FRAMES - 1);
    localparam logic [15:0] HS_LAST = 16'(HITSTOP_FRAMES - 1);
    localparam logic [15:0] RE_LAST = 16'(ROUND_END_FRAMES - 1);
    localparam logic [15:0] FS_LAST = 16'(FRAMES_PER_SEC - 1);

    phase_t      ph;
    logic [15:0] frame_cnt;
    logic [15:0] phase_cnt;
    logic        p1_hit_now, p1_block_now, p2_hit_now, p2_block_now;
    logic        resolving, clear_flags;
    winner_t     round_result;
    logic [1:0]  p1_rounds_inc, p2_rounds_inc;

    // Same rule serves KO (0 vs >0, 0 vs 0) and timeout (higher health wins).
    function automatic winner_t pick_winner(input logic [2:0] h1, input logic [2:0] h2);
        if (h1 > h2)      return WIN_P1;
        else if (h2 > h1) return WIN_P2;
        else              return WIN_DRAW;
    endfunction

    assign phase         = ph;
    assign resolving     = p1_hit_now | p1_block_now | p2_hit_now | p2_block_now;
    assign clear_flags   = (ph == PH_WAIT_START) || (ph == PH_ROUND_END) || (ph == PH_MATCH_OVER);
    assign round_result  = pick_winner(p1_health, p2_health);
    assign p1_rounds_inc = p1_rounds + 2'(round_result == WIN_P1);
    assign p2_rounds_inc = p2_rounds + 2'(round_result == WIN_P2);

    hit_resolver #(.HIT_RANGE(HIT_RANGE), .BACK_CODE(ST_RIGHT)) u_p1_atk (
        .clk_game(clk_game), .reset(reset), .enable(ph == PH_FIGHT), .clear(clear_flags),
        .near_x(p1_x), .far_x(p2_x), .atk_state(p1_state), .def_state(p2_state),
        .hit(p2_hit_now), .block(p2_block_now)
    );

    hit_resolver #(.HIT_RANGE(HIT_RANGE), .BACK_CODE(ST_LEFT)) u_p2_atk (
        .clk_game(clk_game), .reset(reset), .enable(ph == PH_FIGHT), .clear(clear_flags),
        .near_x(p1_x), .far_x(p2_x), .atk_state(p2_state), .def_state(p1_state),
        .hit(p1_hit_now), .block(p1_block_now)
    );

    always_ff @(posedge clk_game or posedge reset) begin
        if (reset) begin
            ph        <= PH_WAIT_START;
            p1_health <= START_H;
            p2_health <= START_H;
            p1_rounds <= 2'd0;
            p2_rounds <= 2'd0;
            timer_sec <= SECS;
            winner    <= WIN_NONE;
            frame_cnt <= 16'd0;
            phase_cnt <= 16'd0;
            p1_freeze <= 1'b1;
            p2_freeze <= 1'b1;
            p1_hit    <= 1'b0;
            p2_hit    <= 1'b0;
            p1_block  <= 1'b0;
            p2_block  <= 1'b0;
        end else begin
            p1_hit   <= 1'b0;
            p2_hit   <= 1'b0;
            p1_block <= 1'b0;
            p2_block <= 1'b0;
            case (ph)
                PH_WAIT_START, PH_MATCH_OVER: if (start_button) begin
                    p1_health <= START_H;
                    p2_health <= START_H;
                    timer_sec <= SECS;
                    frame_cnt <= 16'd0;
                    phase_cnt <= 16'd0;
                    p1_rounds <= 2'd0;
                    p2_rounds <= 2'd0;
                    winner    <= WIN_NONE;
                    ph        <= PH_COUNTDOWN;
                end
                PH_COUNTDOWN: if (phase_cnt == CD_LAST) begin
                    phase_cnt <= 16'd0;
                    p1_freeze <= 1'b0;
                    p2_freeze <= 1'b0;
                    ph        <= PH_FIGHT;
                end else begin
                    phase_cnt <= phase_cnt + 16'd1;
                end
                PH_FIGHT: if (resolving) begin
                    // The resolution frame does not advance the round clock.
                    p1_hit    <= p1_hit_now;
                    p2_hit    <= p2_hit_now;
                    p1_block  <= p1_block_now;
                    p2_block  <= p2_block_now;
                    if (p1_hit_now && p1_health != 3'd0) p1_health <= p1_health - 3'd1;
                    if (p2_hit_now && p2_health != 3'd0) p2_health <= p2_health - 3'd1;
                    phase_cnt <= 16'd0;
                    p1_freeze <= 1'b1;
                    p2_freeze <= 1'b1;
                    ph        <= PH_HITSTOP;
                end else if (frame_cnt == FS_LAST) begin
                    frame_cnt <= 16'd0;
                    timer_sec <= timer_sec - 7'd1;
                    if (timer_sec <= 7'd1) begin
                        winner    <= round_result;
                        p1_rounds <= p1_rounds_inc;
                        p2_rounds <= p2_rounds_inc;
                        phase_cnt <= 16'd0;
                        p1_freeze <= 1'b1;
                        p2_freeze <= 1'b1;
                        ph        <= PH_ROUND_END;
                    end
                end else begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
                PH_HITSTOP: if (phase_cnt == HS_LAST) begin
                    phase_cnt <= 16'd0;
                    if (p1_health == 3'd0 || p2_health == 3'd0) begin
                        winner    <= round_result;
                        p1_rounds <= p1_rounds_inc;
                        p2_rounds <= p2_rounds_inc;
                        ph        <= PH_ROUND_END;
                    end else begin
                        p1_freeze <= 1'b0;
                        p2_freeze <= 1'b0;
                        ph        <= PH_FIGHT;
                    end
                end else begin
                    phase_cnt <= phase_cnt + 16'd1;
                end
                PH_ROUND_END: if (phase_cnt == RE_LAST) begin
                    phase_cnt <= 16'd0;
                    if (p1_rounds == RW || p2_rounds == RW) begin
                        ph <= PH_MATCH_OVER;
                    end else begin
                        p1_health <= START_H;
                        p2_health <= START_H;
                        timer_sec <= SECS;
                        frame_cnt <= 16'd0;
                        winner    <= WIN_NONE;
                        ph        <= PH_COUNTDOWN;
                    end
                end else begin
                    phase_cnt <= phase_cnt + 16'd1;
                end
                default: ph <= PH_WAIT_START;
            endcase
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: vector table plus match-flow sequences.
module tb_round_controller;
    import round_controller_pkg::*;

    logic       clk_game = 1'b0;
    logic       reset, start_button;
    logic [9:0] p1_x, p2_x;
    logic [3:0] p1_state, p2_state;
    logic       p1_freeze, p2_freeze, p1_hit, p2_hit, p1_block, p2_block;
    logic [2:0] p1_health, p2_health, phase;
    logic [1:0] p1_rounds, p2_rounds, winner;
    logic [6:0] timer_sec;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x1, x2, s1, s2;
        int e1h, e2h, e1b, e2b, eboth;
        int eh1, eh2, ehs;
    } vec_t;

    vec_t vecs[11];
    vec_t exp_q[$];

    always #5 clk_game = ~clk_game;

    round_controller dut (
        .clk_game(clk_game), .reset(reset), .start_button(start_button),
        .p1_x(p1_x), .p2_x(p2_x), .p1_state(p1_state), .p2_state(p2_state),
        .p1_freeze(p1_freeze), .p2_freeze(p2_freeze),
        .p1_hit(p1_hit), .p2_hit(p2_hit), .p1_block(p1_block), .p2_block(p2_block),
        .p1_health(p1_health), .p2_health(p2_health),
        .p1_rounds(p1_rounds), .p2_rounds(p2_rounds),
        .phase(phase), .timer_sec(timer_sec), .winner(winner)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_game);
        #1;
    endtask

    task automatic wait_phase(input logic [2:0] ph, input int limit, input string name);
        int n = 0;
        while (phase != ph && n < limit) begin
            tick();
            n++;
        end
        check({name, " reached"}, int'(phase), int'(ph));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start_button = 1'b0;
        p1_state = ST_IDLE;
        p2_state = ST_IDLE;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic start_match();
        start_button = 1'b1;
        tick();
        start_button = 1'b0;
        wait_phase(PH_FIGHT, 200, "fight");
    endtask

    // One P1 (or trade) attack frame, then idle until the hitstop ends.
    task automatic strike(input logic both);
        int n = 0;
        p1_state = ST_ATTACK_1_ACTIVE;
        p2_state = both ? ST_ATTACK_1_ACTIVE : ST_IDLE;
        tick();
        p1_state = ST_IDLE;
        p2_state = ST_IDLE;
        while (phase == PH_HITSTOP && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " phase"}, int'(phase), int'(PH_WAIT_START));
        check({tag, " p1_health"}, int'(p1_health), 3);
        check({tag, " p2_health"}, int'(p2_health), 3);
        check({tag, " p1_rounds"}, int'(p1_rounds), 0);
        check({tag, " p2_rounds"}, int'(p2_rounds), 0);
        check({tag, " timer"}, int'(timer_sec), 60);
        check({tag, " winner"}, int'(winner), 0);
        check({tag, " freezes"}, int'({p1_freeze, p2_freeze}), 3);
        check({tag, " pulses"}, int'({p1_hit, p2_hit, p1_block, p2_block}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n, m, c1h, c2h, c1b, c2b, cb, hs;
        vec_t e;

        vecs = '{
            '{300, 360, 4, 0,  0, 1, 0, 0, 0,  3, 2, 8},
            '{300, 360, 4, 2,  0, 0, 0, 1, 0,  3, 3, 8},
            '{300, 350, 4, 4,  1, 1, 0, 0, 1,  2, 2, 8},
            '{300, 371, 4, 0,  0, 0, 0, 0, 0,  3, 3, 0},
            '{300, 370, 4, 0,  0, 1, 0, 0, 0,  3, 2, 8},
            '{400, 300, 4, 0,  0, 0, 0, 0, 0,  3, 3, 0},
            '{300, 330, 0, 7,  1, 0, 0, 0, 0,  2, 3, 8},
            '{300, 330, 1, 7,  0, 0, 1, 0, 0,  3, 3, 8},
            '{300, 330, 2, 7,  1, 0, 0, 0, 0,  2, 3, 8},
            '{300, 330, 3, 6,  0, 0, 0, 0, 0,  3, 3, 0},
            '{  0,   0, 7, 0,  0, 1, 0, 0, 0,  3, 2, 8}
        };

        p1_x = 10'd300;
        p2_x = 10'd360;
        do_reset();
        check_reset_values("reset");

        // Countdown length, freezes, and start ignored during FIGHT.
        start_button = 1'b1;
        tick();
        start_button = 1'b0;
        check("cd phase", int'(phase), int'(PH_COUNTDOWN));
        n = 0;
        while (phase == PH_COUNTDOWN && n < 300) begin
            check("cd freeze", int'(p1_freeze & p2_freeze), 1);
            n++;
            tick();
        end
        check("cd length", n, 120);
        check("fight freeze", int'({p1_freeze, p2_freeze}), 0);
        start_button = 1'b1;
        repeat (5) tick();
        start_button = 1'b0;
        check("start ignored", int'(phase), int'(PH_FIGHT));

        // Vector table: one attack frame pattern per row, scoreboarded.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            p1_x = 10'(vecs[i].x1);
            p2_x = 10'(vecs[i].x2);
            start_match();
            exp_q.push_back(vecs[i]);
            p1_state = 4'(vecs[i].s1);
            p2_state = 4'(vecs[i].s2);
            c1h = 0; c2h = 0; c1b = 0; c2b = 0; cb = 0; hs = 0;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (k == 2) begin
                    p1_state = ST_IDLE;
                    p2_state = ST_IDLE;
                end
                c1h += int'(p1_hit);
                c2h += int'(p2_hit);
                c1b += int'(p1_block);
                c2b += int'(p2_block);
                cb  += int'(p1_hit & p2_hit);
                hs  += int'(phase == PH_HITSTOP);
            end
            e = exp_q.pop_front();
            check($sformatf("v%0d p1_hit", i), c1h, e.e1h);
            check($sformatf("v%0d p2_hit", i), c2h, e.e2h);
            check($sformatf("v%0d p1_block", i), c1b, e.e1b);
            check($sformatf("v%0d p2_block", i), c2b, e.e2b);
            check($sformatf("v%0d same-cycle", i), cb, e.eboth);
            check($sformatf("v%0d p1_health", i), int'(p1_health), e.eh1);
            check($sformatf("v%0d p2_health", i), int'(p2_health), e.eh2);
            check($sformatf("v%0d hitstop", i), hs, e.ehs);
        end

        // Timeout with no input: draw, no rounds awarded, back to countdown.
        do_reset();
        p1_x = 10'd100;
        p2_x = 10'd500;
        start_match();
        n = 0;
        while (phase == PH_FIGHT && n < 4000) begin
            n++;
            if (n == 61) check("timer 59", int'(timer_sec), 59);
            tick();
        end
        check("fight length", n, 3600);
        check("to phase", int'(phase), int'(PH_ROUND_END));
        check("to winner", int'(winner), 3);
        check("to rounds", int'({p1_rounds, p2_rounds}), 0);
        m = 0;
        while (phase == PH_ROUND_END && m < 200) begin
            check("re freeze", int'(p1_freeze & p2_freeze), 1);
            m++;
            tick();
        end
        check("re length", m, 90);
        check("to next", int'(phase), int'(PH_COUNTDOWN));
        check("to winner clr", int'(winner), 0);
        check("to timer", int'(timer_sec), 60);

        // Double KO through three trades.
        do_reset();
        p1_x = 10'd300;
        p2_x = 10'd350;
        start_match();
        repeat (3) strike(1'b1);
        check("dko phase", int'(phase), int'(PH_ROUND_END));
        check("dko winner", int'(winner), 3);
        check("dko health", int'({p1_health, p2_health}), 0);
        check("dko rounds", int'({p1_rounds, p2_rounds}), 0);

        // P1 wins two rounds by KO -> match over, then restart.
        do_reset();
        p1_x = 10'd300;
        p2_x = 10'd360;
        start_match();
        repeat (3) strike(1'b0);
        check("r1 phase", int'(phase), int'(PH_ROUND_END));
        check("r1 winner", int'(winner), 1);
        check("r1 p1_rounds", int'(p1_rounds), 1);
        check("r1 p2_health", int'(p2_health), 0);
        wait_phase(PH_COUNTDOWN, 100, "r2 countdown");
        check("r2 winner clr", int'(winner), 0);
        check("r2 p2_health", int'(p2_health), 3);
        wait_phase(PH_FIGHT, 200, "r2 fight");
        repeat (3) strike(1'b0);
        check("r2 p1_rounds", int'(p1_rounds), 2);
        check("r2 p2_rounds", int'(p2_rounds), 0);
        wait_phase(PH_MATCH_OVER, 100, "match over");
        repeat (5) tick();
        check("mo winner", int'(winner), 1);
        check("mo freeze", int'({p1_freeze, p2_freeze}), 3);
        start_button = 1'b1;
        tick();
        start_button = 1'b0;
        check("restart phase", int'(phase), int'(PH_COUNTDOWN));
        check("restart rounds", int'(p1_rounds), 0);
        check("restart winner", int'(winner), 0);

        // Asynchronous reset mid-FIGHT with match state built up.
        do_reset();
        start_match();
        repeat (3) strike(1'b0);
        wait_phase(PH_FIGHT, 400, "rst fight");
        strike(1'b0);
        check("rst pre health", int'(p2_health), 2);
        repeat (10) tick();
        #2 reset = 1'b1;
        #1;
        check_reset_values("async reset");
        p1_state = ST_ATTACK_1_ACTIVE;
        tick();
        reset = 1'b0;
        tick();
        check_reset_values("post reset");
        p1_state = ST_IDLE;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
